// File: rtl/add_sub_serial.sv
// Multi-cycle add/subtract unit: CHUNK_WIDTH bits per cycle, LSB chunk first, registered inter-chunk carry.
// Optional result saturation on signed overflow is enabled by defining ADD_SUB_SAT_EN.
module add_sub_serial #(
  parameter int DATA_WIDTH  = 32,
  parameter int CHUNK_WIDTH = 8
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  start,
  input  logic                  op,
  input  logic [DATA_WIDTH-1:0] operand_a,
  input  logic [DATA_WIDTH-1:0] operand_b,
  output logic                  busy,
  output logic [DATA_WIDTH-1:0] result,
  output logic                  carry_out,
  output logic                  overflow,
  output logic                  complete,
  output logic [1:0]            state_dbg
);

  // Handshake: start is a request taken only in IDLE (operands/op captured on that edge);
  // complete is a one-cycle pulse marking result/flags valid, which then hold until the next accepted start.

  localparam int NUM_CHUNKS = DATA_WIDTH / CHUNK_WIDTH;
  localparam int CNT_W      = (NUM_CHUNKS > 1) ? $clog2(NUM_CHUNKS) : 1;
  localparam int IDX_W      = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_CHUNK = CNT_W'(NUM_CHUNKS - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COMPUTE = 2'd1,
    DONE    = 2'd2
  } state_t;

  state_t                  state;
  state_t                  state_next;
  logic [DATA_WIDTH-1:0]   a_q;
  logic [DATA_WIDTH-1:0]   b_q;
  logic                    carry_q;
  logic [CNT_W-1:0]        cnt;
  logic [IDX_W-1:0]        base;
  logic [CHUNK_WIDTH:0]    chunk_sum;
  logic                    ovf_calc;

  assign state_dbg = state;
  assign base      = IDX_W'(int'(cnt) * CHUNK_WIDTH);
  assign chunk_sum = {1'b0, a_q[base +: CHUNK_WIDTH]}
                   + {1'b0, b_q[base +: CHUNK_WIDTH]}
                   + {{CHUNK_WIDTH{1'b0}}, carry_q};
  // b_q already holds ~b for subtraction, so this is the usual same-sign-in, different-sign-out test.
  assign ovf_calc  = (a_q[DATA_WIDTH-1] == b_q[DATA_WIDTH-1]) &&
                     (result[DATA_WIDTH-1] != a_q[DATA_WIDTH-1]);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = COMPUTE;
      COMPUTE: if (cnt == LAST_CHUNK) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      a_q       <= '0;
      b_q       <= '0;
      carry_q   <= 1'b0;
      cnt       <= '0;
      result    <= '0;
      carry_out <= 1'b0;
      overflow  <= 1'b0;
      busy      <= 1'b0;
      complete  <= 1'b0;
    end else begin
      complete <= 1'b0;
      if (complete) busy <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            a_q     <= operand_a;
            b_q     <= op ? ~operand_b : operand_b;
            carry_q <= op;
            cnt     <= '0;
            busy    <= 1'b1;
          end
        end
        COMPUTE: begin
          result[base +: CHUNK_WIDTH] <= chunk_sum[CHUNK_WIDTH-1:0];
          carry_q <= chunk_sum[CHUNK_WIDTH];
          cnt     <= cnt + 1'b1;
        end
        DONE: begin
          carry_out <= carry_q;
          overflow  <= ovf_calc;
          complete  <= 1'b1;
`ifdef ADD_SUB_SAT_EN
          // Sign of a tells the overflow direction: a >= 0 means positive overflow.
          if (ovf_calc)
            result <= {a_q[DATA_WIDTH-1], {(DATA_WIDTH-1){~a_q[DATA_WIDTH-1]}}};
`endif
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_add_sub_serial.sv
// Directed bench for add_sub_serial: default 32/8 instance plus 32/32 and 32/4 instances for the parameter sweep.
// Expectations follow ADD_SUB_SAT_EN when it is defined.
module tb_add_sub_serial;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic        op = 1'b0;
  logic [31:0] a = '0;
  logic [31:0] b = '0;

  logic        busy_8, carry_8, ovf_8, complete_8;
  logic [31:0] result_8;
  logic [1:0]  state_8;
  logic        busy_32, carry_32, ovf_32, complete_32;
  logic [31:0] result_32;
  logic [1:0]  state_32;
  logic        busy_4, carry_4, ovf_4, complete_4;
  logic [31:0] result_4;
  logic [1:0]  state_4;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clock = ~clock;

  add_sub_serial #(.DATA_WIDTH(32), .CHUNK_WIDTH(8)) dut_8 (
    .clock(clock), .reset_n(reset_n), .start(start), .op(op),
    .operand_a(a), .operand_b(b), .busy(busy_8), .result(result_8),
    .carry_out(carry_8), .overflow(ovf_8), .complete(complete_8), .state_dbg(state_8)
  );

  add_sub_serial #(.DATA_WIDTH(32), .CHUNK_WIDTH(32)) dut_32 (
    .clock(clock), .reset_n(reset_n), .start(start), .op(op),
    .operand_a(a), .operand_b(b), .busy(busy_32), .result(result_32),
    .carry_out(carry_32), .overflow(ovf_32), .complete(complete_32), .state_dbg(state_32)
  );

  add_sub_serial #(.DATA_WIDTH(32), .CHUNK_WIDTH(4)) dut_4 (
    .clock(clock), .reset_n(reset_n), .start(start), .op(op),
    .operand_a(a), .operand_b(b), .busy(busy_4), .result(result_4),
    .carry_out(carry_4), .overflow(ovf_4), .complete(complete_4), .state_dbg(state_4)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Called at posedge+1; returns at posedge+1 after the accepting edge.
  task automatic issue(input logic [31:0] ia, input logic [31:0] ib, input logic iop);
    a     = ia;
    b     = ib;
    op    = iop;
    start = 1'b1;
    @(posedge clock);
    #1;
    start = 1'b0;
  endtask

  // Cycles until complete_8 is seen, -1 if it never arrives within the budget.
  task automatic wait_done_8(output int lat);
    lat = -1;
    for (int k = 1; k <= 30; k++) begin
      @(posedge clock);
      #1;
      if (complete_8) begin
        lat = k;
        break;
      end
    end
  endtask

  task automatic idle_cycles(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clock);
      #1;
    end
  endtask

  // Reference: whole-word add of a and (possibly inverted) b with carry-in = op.
  function automatic logic [33:0] model(input logic [31:0] x, input logic [31:0] y, input logic o);
    logic [31:0] yb;
    logic [32:0] s;
    logic        v;
    yb = o ? ~y : y;
    s  = {1'b0, x} + {1'b0, yb} + {32'd0, o};
    v  = (x[31] == yb[31]) && (s[31] != x[31]);
`ifdef ADD_SUB_SAT_EN
    if (v) s[31:0] = x[31] ? 32'h8000_0000 : 32'h7FFF_FFFF;
`endif
    return {v, s[32], s[31:0]};
  endfunction

  initial begin
    int          lat;
    int          extra;
    int          lat8, lat32, lat4;
    logic [33:0] exp;
    logic [31:0] va [6];
    logic [31:0] vb [6];
    logic        vo [6];

    // Reset state
    #1;
    check("rst_busy", 32'(busy_8), 32'd0);
    check("rst_result", result_8, 32'd0);
    check("rst_complete", 32'(complete_8), 32'd0);
    check("rst_flags", {30'd0, carry_8, ovf_8}, 32'd0);
    check("rst_state", 32'(state_8), 32'd0);
    idle_cycles(2);
    reset_n = 1'b1;
    idle_cycles(1);

    // 1: add wrap
    issue(32'hFFFF_FFFF, 32'h0000_0001, 1'b0);
    check("t1_busy", 32'(busy_8), 32'd1);
    wait_done_8(lat);
    check("t1_latency", lat, 32'd5);
    check("t1_result", result_8, 32'h0000_0000);
    check("t1_carry", 32'(carry_8), 32'd1);
    check("t1_ovf", 32'(ovf_8), 32'd0);
    idle_cycles(1);
    check("t1_pulse_width", 32'(complete_8), 32'd0);
    check("t1_busy_drop", 32'(busy_8), 32'd0);

    // 2: positive signed overflow
    issue(32'h7FFF_FFFF, 32'h0000_0001, 1'b0);
    wait_done_8(lat);
    check("t2_latency", lat, 32'd5);
`ifdef ADD_SUB_SAT_EN
    check("t2_result", result_8, 32'h7FFF_FFFF);
`else
    check("t2_result", result_8, 32'h8000_0000);
`endif
    check("t2_ovf", 32'(ovf_8), 32'd1);
    check("t2_carry", 32'(carry_8), 32'd0);

    // 2b: negative signed overflow via subtract
    issue(32'h8000_0000, 32'h0000_0001, 1'b1);
    wait_done_8(lat);
`ifdef ADD_SUB_SAT_EN
    check("t2b_result", result_8, 32'h8000_0000);
`else
    check("t2b_result", result_8, 32'h7FFF_FFFF);
`endif
    check("t2b_ovf", 32'(ovf_8), 32'd1);
    check("t2b_carry", 32'(carry_8), 32'd1);

    // 3: subtract with borrow, then back-to-back
    issue(32'd5, 32'd7, 1'b1);
    wait_done_8(lat);
    check("t3a_result", result_8, 32'hFFFF_FFFE);
    check("t3a_carry", 32'(carry_8), 32'd0);
    check("t3a_ovf", 32'(ovf_8), 32'd0);
    issue(32'd7, 32'd5, 1'b1);
    check("t3_b2b_pulse_drop", 32'(complete_8), 32'd0);
    check("t3_b2b_busy", 32'(busy_8), 32'd1);
    wait_done_8(lat);
    check("t3b_latency", lat, 32'd5);
    check("t3b_result", result_8, 32'h0000_0002);
    check("t3b_carry", 32'(carry_8), 32'd1);
    check("t3b_ovf", 32'(ovf_8), 32'd0);
    idle_cycles(12);

    // 4: start during busy is ignored
    issue(32'h0000_0010, 32'h0000_0020, 1'b0);
    idle_cycles(1);
    a     = 32'hDEAD_BEEF;
    b     = 32'h0000_0001;
    start = 1'b1;
    @(posedge clock);
    #1;
    start = 1'b0;
    wait_done_8(lat);
    check("t4_latency", lat, 32'd3);
    check("t4_result", result_8, 32'h0000_0030);
    extra = 0;
    for (int k = 0; k < 10; k++) begin
      @(posedge clock);
      #1;
      if (complete_8) extra++;
    end
    check("t4_extra_complete", extra, 32'd0);
    idle_cycles(12);

    // 5: reset mid-operation
    issue(32'h1234_5678, 32'h1111_1111, 1'b0);
    idle_cycles(2);
    reset_n = 1'b0;
    #1;
    check("t5_rst_result", result_8, 32'd0);
    check("t5_rst_busy", 32'(busy_8), 32'd0);
    check("t5_rst_state", 32'(state_8), 32'd0);
    idle_cycles(2);
    reset_n = 1'b1;
    extra = 0;
    for (int k = 0; k < 8; k++) begin
      @(posedge clock);
      #1;
      if (complete_8) extra++;
    end
    check("t5_no_complete", extra, 32'd0);
    issue(32'd1, 32'd2, 1'b0);
    wait_done_8(lat);
    check("t5_latency", lat, 32'd5);
    check("t5_result", result_8, 32'd3);
    idle_cycles(12);

    // 6: parameter sweep against the reference model
    va[0] = 32'h0000_0000; vb[0] = 32'h0000_0000; vo[0] = 1'b1;
    va[1] = 32'hFFFF_FFFF; vb[1] = 32'hFFFF_FFFF; vo[1] = 1'b0;
    for (int i = 2; i < 6; i++) begin
      va[i] = $urandom;
      vb[i] = $urandom;
      vo[i] = 1'($urandom_range(0, 1));
    end
    for (int i = 0; i < 6; i++) begin
      issue(va[i], vb[i], vo[i]);
      lat8  = -1;
      lat32 = -1;
      lat4  = -1;
      for (int k = 1; k <= 20; k++) begin
        @(posedge clock);
        #1;
        if (complete_8  && lat8  < 0) lat8  = k;
        if (complete_32 && lat32 < 0) lat32 = k;
        if (complete_4  && lat4  < 0) lat4  = k;
      end
      exp = model(va[i], vb[i], vo[i]);
      check("sw_lat_c8", lat8, 32'd5);
      check("sw_lat_c32", lat32, 32'd2);
      check("sw_lat_c4", lat4, 32'd9);
      check("sw_res_c8", result_8, exp[31:0]);
      check("sw_res_c32", result_32, exp[31:0]);
      check("sw_res_c4", result_4, exp[31:0]);
      check("sw_flags_c8", {30'd0, ovf_8, carry_8}, {30'd0, exp[33:32]});
      check("sw_flags_c32", {30'd0, ovf_32, carry_32}, {30'd0, exp[33:32]});
      check("sw_flags_c4", {30'd0, ovf_4, carry_4}, {30'd0, exp[33:32]});
      check("sw_idle", {24'd0, 2'd0, state_8, state_32, state_4}, 32'd0);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
